// File: rtl/bus_master_if.sv
// Master-side bus interface: turns a level-held CPU/DMA request into one
// arbitrated, address-strobed bus transfer, with a watchdog for dead slaves.
module bus_master_if #(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bus_req_;
    logic               r_bus_as_;
    logic               r_bus_rw;
    logic [ADDR_W-1:0]  r_bus_addr;
    logic [DATA_W-1:0]  r_bus_wr_data;
    logic [DATA_W-1:0]  r_cpu_rd_data;
    logic               r_cpu_ack;
    logic               r_cpu_err;

    // Transfer sequencer: request, strobe, wait for ready or watchdog expiry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_bus_req_    <= 1'b1;
            r_bus_as_     <= 1'b1;
            r_bus_rw      <= 1'b1;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
            r_cpu_rd_data <= '0;
            r_cpu_ack     <= 1'b0;
            r_cpu_err     <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses
            r_cpu_ack <= 1'b0;
            r_cpu_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // the still-held request of the transfer just acked is ignored
                    if (cpu_req && !r_cpu_ack) begin
                        r_bus_rw      <= cpu_rw;
                        r_bus_addr    <= cpu_addr;
                        r_bus_wr_data <= cpu_wr_data;
                        r_bus_req_    <= 1'b0;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!bus_grnt_) begin
                        r_bus_as_ <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_ACCESS;
                    end
                end
                S_ACCESS, S_WAIT: begin
                    r_bus_as_ <= 1'b1;
                    if (!bus_rdy_) begin
                        // ready beats a simultaneous watchdog expiry
                        r_cpu_ack <= 1'b1;
                        if (r_bus_rw) begin
                            r_cpu_rd_data <= bus_rd_data;
                        end
                        r_bus_req_ <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_cpu_ack     <= 1'b1;
                        r_cpu_err     <= 1'b1;
                        r_cpu_rd_data <= '0;
                        r_bus_req_    <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rd_data = r_cpu_rd_data;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_err     = r_cpu_err;
    assign bus_req_    = r_bus_req_;
    assign bus_as_     = r_bus_as_;
    assign bus_rw      = r_bus_rw;
    assign bus_addr    = r_bus_addr;
    assign bus_wr_data = r_bus_wr_data;

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if: a driver issues CPU transfers and pushes
// the expected outcome, a bus responder plays arbiter+slave, a monitor checks.
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req;
    logic          cpu_rw;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wr_data;
    logic [DW-1:0] cpu_rd_data;
    logic          cpu_ack;
    logic          cpu_err;
    logic          bus_req_;
    logic          bus_grnt_;
    logic          bus_as_;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy_;

    bus_master_if #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_addr   (cpu_addr),
        .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data),
        .cpu_ack    (cpu_ack),
        .cpu_err    (cpu_err),
        .bus_req_   (bus_req_),
        .bus_grnt_  (bus_grnt_),
        .bus_as_    (bus_as_),
        .bus_rw     (bus_rw),
        .bus_addr   (bus_addr),
        .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data),
        .bus_rdy_   (bus_rdy_)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            req_cyc;
        int            as_cyc;
        int            ack_cyc;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    exp_t          q[$];
    exp_t          m_e;
    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] last_rd     = '0;
    bit            rst_chk     = 1'b0;
    bit            resp_en     = 1'b0;

    // responder knobs for the transfer in flight
    int            p_g = 0;
    int            p_w = 0;
    logic [DW-1:0] p_rdv = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Arbiter + slave: grant p_g cycles after the request falls, ready p_w
    // cycles after the strobe; grant is scrambled once the strobe is seen.
    int gcnt = 0;
    int wcnt = 0;
    bit phase = 1'b0;
    initial begin
        bus_grnt_   = 1'b1;
        bus_rdy_    = 1'b1;
        bus_rd_data = '0;
        forever begin
            @(posedge clk);
            #1;
            bus_rd_data = DW'($urandom);
            if (!resp_en) begin
                bus_grnt_ = 1'($urandom);
                bus_rdy_  = 1'($urandom);
                gcnt = 0; wcnt = 0; phase = 1'b0;
            end else if (bus_req_) begin
                bus_grnt_ = 1'b1;
                bus_rdy_  = 1'b1;
                gcnt = 0; wcnt = 0; phase = 1'b0;
            end else begin
                if (!bus_as_) phase = 1'b1;
                if (!phase) begin
                    bus_grnt_ = (gcnt == p_g) ? 1'b0 : 1'b1;
                    bus_rdy_  = 1'b1;
                    gcnt++;
                end else begin
                    bus_grnt_ = 1'($urandom);
                    bus_rdy_  = (wcnt == p_w) ? 1'b0 : 1'b1;
                    if (wcnt == p_w) bus_rd_data = p_rdv;
                    wcnt++;
                end
            end
        end
    end

    // Monitor: samples on the falling edge and pops the scoreboard on each ack.
    logic prev_req = 1'b1;
    logic prev_as  = 1'b1;
    int   obs_req  = -1;
    int   obs_as   = -1;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_chk) begin
                check("rst_bus_req_",    bus_req_,    1);
                check("rst_bus_as_",     bus_as_,     1);
                check("rst_bus_rw",      bus_rw,      1);
                check("rst_bus_addr",    bus_addr,    0);
                check("rst_bus_wr_data", bus_wr_data, 0);
                check("rst_cpu_rd_data", cpu_rd_data, 0);
                check("rst_cpu_ack",     cpu_ack,     0);
                check("rst_cpu_err",     cpu_err,     0);
            end
            if (resp_en) begin
                if (prev_req && !bus_req_) obs_req = cyc;
                if (!bus_as_) begin
                    check("strobe_width", prev_as, 1);
                    obs_as = cyc;
                    if (q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL spurious_strobe: got strobe, want none (cycle %0d)", cyc);
                    end else begin
                        check("strobe_addr",  bus_addr,    q[0].addr);
                        check("strobe_rw",    bus_rw,      q[0].rw);
                        check("strobe_wdata", bus_wr_data, q[0].wdata);
                    end
                end
                if (cpu_ack) begin
                    if (q.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL spurious_ack: got ack, want none (cycle %0d)", cyc);
                    end else begin
                        m_e = q.pop_front();
                        check("req_cycle",    obs_req,     m_e.req_cyc);
                        check("strobe_cycle", obs_as,      m_e.as_cyc);
                        check("ack_cycle",    cyc,         m_e.ack_cyc);
                        check("rd_data",      cpu_rd_data, m_e.rd);
                        check("err",          cpu_err,     m_e.err);
                        check("ack_req_high", bus_req_,    1);
                        check("held_addr",    bus_addr,    m_e.addr);
                        check("held_wdata",   bus_wr_data, m_e.wdata);
                    end
                end else if (cpu_err) begin
                    vectors++; miscompares++;
                    $display("FAIL err_without_ack: got err=1, want 0 (cycle %0d)", cyc);
                end
            end
            prev_req = bus_req_;
            prev_as  = bus_as_;
        end
    end

    // Reference model: request accepted at cycle n completes at
    // n + 3 + grant delay + min(wait states, T); wait states beyond T time out.
    task automatic issue(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input logic [DW-1:0] rdv, input int g, input int w, output int n);
        exp_t e;
        int   eff;
        n     = cpu_ack ? cyc + 1 : cyc;
        p_g   = g;
        p_w   = w;
        p_rdv = rdv;
        cpu_req     = 1'b1;
        cpu_rw      = rw;
        cpu_addr    = a;
        cpu_wr_data = wd;
        eff       = (w > T) ? T : w;
        e.req_cyc = n + 1;
        e.as_cyc  = n + 2 + g;
        e.ack_cyc = n + 3 + g + eff;
        e.rw      = rw;
        e.addr    = a;
        e.wdata   = wd;
        e.err     = (w > T);
        e.rd      = e.err ? '0 : (rw ? rdv : last_rd);
        last_rd   = e.rd;
        q.push_back(e);
    endtask

    task automatic wait_ack(input bit hold);
        int k = 0;
        while (1) begin
            @(posedge clk);
            #1;
            k++;
            if (cpu_ack) break;
            if (k > 60) begin
                vectors++; miscompares++;
                $display("FAIL ack_wait: got no ack in 60 cycles, want ack (cycle %0d)", cyc);
                q.delete();
                break;
            end
        end
        if (!hold) cpu_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish (cycle %0d)", cyc);
        $fatal(1, "bench timed out");
    end

    int n;
    initial begin
        rst         = 1'b1;
        cpu_req     = 1'($urandom);
        cpu_rw      = 1'($urandom);
        cpu_addr    = AW'($urandom);
        cpu_wr_data = DW'($urandom);
        repeat (2) begin
            tick();
            cpu_req     = 1'($urandom);
            cpu_rw      = 1'($urandom);
            cpu_addr    = AW'($urandom);
            cpu_wr_data = DW'($urandom);
        end
        rst_chk = 1'b1;
        tick();
        rst_chk = 1'b0;
        rst     = 1'b0;
        cpu_req = 1'b0;
        resp_en = 1'b1;
        last_rd = '0;
        tick();

        // zero-wait immediate-grant read
        issue(1'b1, 30'h100, 32'h0, 32'hDEADBEEF, 0, 0, n);
        wait_ack(1'b0);
        tick();
        // write, grant after 5 cycles, 3 wait states
        issue(1'b0, 30'h2A5, 32'h12345678, 32'hCAFEF00D, 5, 3, n);
        wait_ack(1'b0);
        tick();
        // slave never ready: watchdog expiry
        issue(1'b1, 30'h3F0, 32'h0, 32'h55AA55AA, 0, T + 1, n);
        wait_ack(1'b0);
        tick();
        // ready on the last tolerated cycle
        issue(1'b1, 30'h3F4, 32'h0, 32'hA5A5A5A5, 1, T, n);
        wait_ack(1'b0);
        tick();

        // reset while waiting on a slow slave
        issue(1'b1, 30'h77, 32'h0, 32'h11111111, 0, T + 3, n);
        while (cyc < n + 4) tick();
        rst = 1'b1;
        tick();
        q.delete();
        last_rd = '0;
        cpu_req = 1'b0;
        rst     = 1'b0;
        rst_chk = 1'b1;
        tick();
        rst_chk = 1'b0;
        issue(1'b1, 30'h88, 32'h0, 32'h22222222, 0, 0, n);
        wait_ack(1'b0);
        tick();

        // back-to-back with request held across the ack
        issue(1'b1, 30'h10, 32'h0, 32'h0BADF00D, 0, 0, n);
        wait_ack(1'b1);
        issue(1'b0, 30'h14, 32'h87654321, 32'h0, 0, 0, n);
        wait_ack(1'b0);
        tick();

        for (int i = 0; i < 150; i++) begin
            bit hold;
            hold = 1'($urandom);
            issue(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, T + 2)), n);
            wait_ack(hold);
            if (!hold) repeat ($urandom_range(0, 2)) tick();
        end
        cpu_req = 1'b0;
        repeat (5) tick();
        check("queue_drained", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
